// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch pipeline.
package mips_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
        logic               valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with reset / redirect / stall next-PC selection.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;

    // Sequential increment wraps naturally at 2^32
    assign w_pc_plus4 = r_pc + PC_INC;

    // PC update: reset beats redirect, redirect beats stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= word_align(redirect_pc);
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS IF stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds fetch/stall/flush event counters.
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [31:0]        pc,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt,
`endif
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid
);

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    if_id_t      r_if_id;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (w_pc),
        .pc_plus4    (w_pc_plus4)
    );

    // Word index into instruction memory; wraps at the memory depth
    assign imem_addr = (w_pc >> 2) % MEM_SIZE;
    assign pc        = w_pc;

    // IF/ID register: redirect squashes the wrong-path fetch, stall holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_id <= IF_ID_BUBBLE;
        end else if (redirect) begin
            r_if_id <= IF_ID_BUBBLE;
        end else if (!stall) begin
            r_if_id <= '{instr: imem_data, pc4: w_pc_plus4, valid: 1'b1};
        end
    end

    assign if_id_instr = r_if_id.instr;
    assign if_id_pc4   = r_if_id.pc4;
    assign if_id_valid = r_if_id.valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Event counters; a stall coinciding with a redirect counts only as a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (redirect) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
        end else if (stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
